phase_sense_sequencer: RTL and testbench

//  Parametrised ADC sequencer that derives per-phase current sign and over-current faults for N commutation phases.

---
 rtl/commutation_pkg.sv | 26 ++
 rtl/sign_hysteresis.sv | 58 +++++
 rtl/phase_sense_sequencer.sv | 166 ++++++++++++++++
 tb/tb_phase_sense_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/commutation_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commutation_pkg
//  Description : Shared types and default constants for the phase current
//                sense sequencer: sequencer state encoding, default ADC
//                data/channel widths and default sign/over-current thresholds.
//  Revision    : 1.0  initial release
// ============================================================================
package commutation_pkg;

    typedef enum logic [1:0] {
        c_WAIT_LOCK = 2'd0,
        c_ISSUE     = 2'd1,
        c_WAIT_RSP  = 2'd2
    } seq_state_t;

    localparam int c_DATA_W  = 12;
    localparam int c_CH_W    = 5;
    localparam int c_THR_HI  = 2080;
    localparam int c_THR_LO  = 2016;
    localparam int c_OC_HI   = 3900;
    localparam int c_OC_LO   = 195;
    localparam int c_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/sign_hysteresis.sv
`default_nettype none
// ============================================================================
//  Module      : sign_hysteresis
//  Description : Per-phase current sign with hysteresis and sticky
//                over-current detection, updated on each load strobe.
//  Ports       : clk       in   system clock
//                rst       in   asynchronous reset, active-low
//                i_load    in   accept i_data this cycle
//                i_data    in   ADC sample, unsigned
//                o_sign    out  hysteretic current sign
//                o_oc      out  sticky over-current flag
//  Revision    : 1.0  initial release
// ============================================================================
module sign_hysteresis
    import commutation_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int THR_HI = c_THR_HI,
    parameter int THR_LO = c_THR_LO,
    parameter int OC_HI  = c_OC_HI,
    parameter int OC_LO  = c_OC_LO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_sign,
    output logic              o_oc
);

    localparam logic [DATA_W-1:0] c_THR_HI_V = DATA_W'(THR_HI);
    localparam logic [DATA_W-1:0] c_THR_LO_V = DATA_W'(THR_LO);
    localparam logic [DATA_W-1:0] c_OC_HI_V  = DATA_W'(OC_HI);
    localparam logic [DATA_W-1:0] c_OC_LO_V  = DATA_W'(OC_LO);

    logic r_sign;
    logic r_oc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign <= 1'b0;
            r_oc   <= 1'b0;
        end else if (i_load) begin
            // Samples inside the dead band leave the sign untouched.
            if (i_data > c_THR_HI_V)
                r_sign <= 1'b1;
            else if (i_data < c_THR_LO_V)
                r_sign <= 1'b0;
            if ((i_data >= c_OC_HI_V) || (i_data <= c_OC_LO_V))
                r_oc <= 1'b1;
        end
    end

    assign o_sign = r_sign;
    assign o_oc   = r_oc;

endmodule
`default_nettype wire

// File: rtl/phase_sense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sense_sequencer
//  Description : Round-robin ADC sequencer producing per-phase current sign
//                and sticky over-current / watchdog faults.
//  Ports       : clk, rst (async active-low), enable, adc_locked
//                cmd_valid/cmd_ready/cmd_channel/cmd_sop/cmd_eop  ADC command
//                rsp_valid/rsp_channel/rsp_data                   ADC response
//                current_sign, sign_valid, overcurrent  per-phase outputs
//                fault, timeout_err                     sticky fault lines
//  Revision    : 1.0  initial release
// ============================================================================
module phase_sense_sequencer
    import commutation_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int DATA_W  = c_DATA_W,
    parameter int CH_W    = c_CH_W,
    parameter int CH_BASE = 1,
    parameter int THR_HI  = c_THR_HI,
    parameter int THR_LO  = c_THR_LO,
    parameter int OC_HI   = c_OC_HI,
    parameter int OC_LO   = c_OC_LO,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_locked,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [CH_W-1:0]   cmd_channel,
    output logic              cmd_sop,
    output logic              cmd_eop,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    output logic [N_CH-1:0]   current_sign,
    output logic [N_CH-1:0]   sign_valid,
    output logic [N_CH-1:0]   overcurrent,
    output logic              fault,
    output logic              timeout_err
);

    localparam int c_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_CH - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);

    seq_state_t          r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_cmd_valid;
    logic [CH_W-1:0]     r_cmd_channel;
    logic [N_CH-1:0]     r_sign_valid;
    logic                r_fault;
    logic                r_timeout_err;

    logic                w_run;
    logic                w_match;
    logic [c_IDX_W-1:0]  w_idx_next;
    logic [CH_W-1:0]     w_chan_next;
    logic [N_CH-1:0]     w_load;
    logic [N_CH-1:0]     w_sign;
    logic [N_CH-1:0]     w_oc;

    assign w_run       = adc_locked & enable;
    // cmd_channel holds the outstanding channel through WAIT_RSP, so it is
    // the reference for response matching.
    assign w_match     = w_run && (r_state == c_WAIT_RSP) && rsp_valid &&
                         (rsp_channel == r_cmd_channel);
    assign w_idx_next  = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_chan_next = CH_W'(CH_BASE) + CH_W'(w_idx_next);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_WAIT_LOCK;
            r_idx         <= '0;
            r_wd          <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_channel <= '0;
            r_sign_valid  <= '0;
            r_fault       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_fault <= |w_oc;
            if (!w_run) begin
                // Loss of lock/enable abandons any outstanding conversion.
                r_state      <= c_WAIT_LOCK;
                r_idx        <= '0;
                r_wd         <= '0;
                r_cmd_valid  <= 1'b0;
                r_sign_valid <= '0;
            end else begin
                case (r_state)
                    c_WAIT_LOCK: begin
                        r_state       <= c_ISSUE;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_channel <= CH_W'(CH_BASE) + CH_W'(r_idx);
                    end
                    c_ISSUE: begin
                        if (cmd_ready) begin
                            r_state     <= c_WAIT_RSP;
                            r_cmd_valid <= 1'b0;
                            r_wd        <= '0;
                        end
                    end
                    c_WAIT_RSP: begin
                        // A match on the expiry cycle takes priority.
                        if (w_match) begin
                            r_sign_valid[r_idx] <= 1'b1;
                            r_idx         <= w_idx_next;
                            r_cmd_channel <= w_chan_next;
                            r_cmd_valid   <= 1'b1;
                            r_state       <= c_ISSUE;
                        end else if (r_wd == c_WD_LAST) begin
                            r_timeout_err       <= 1'b1;
                            r_sign_valid[r_idx] <= 1'b0;
                            r_idx         <= w_idx_next;
                            r_cmd_channel <= w_chan_next;
                            r_cmd_valid   <= 1'b1;
                            r_state       <= c_ISSUE;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= c_WAIT_LOCK;
                        r_cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_phase
        assign w_load[i] = w_match && (r_idx == c_IDX_W'(i));

        sign_hysteresis #(
            .DATA_W (DATA_W),
            .THR_HI (THR_HI),
            .THR_LO (THR_LO),
            .OC_HI  (OC_HI),
            .OC_LO  (OC_LO)
        ) u_sign (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[i]),
            .i_data (rsp_data),
            .o_sign (w_sign[i]),
            .o_oc   (w_oc[i])
        );
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_channel  = r_cmd_channel;
    assign cmd_sop      = 1'b1;
    assign cmd_eop      = 1'b1;
    assign current_sign = w_sign;
    assign sign_valid   = r_sign_valid;
    assign overcurrent  = w_oc;
    assign fault        = r_fault;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_phase_sense_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sense_sequencer
//  Description : Directed, table-driven bench for phase_sense_sequencer
//                (N_CH=3, CH_BASE=1, TIMEOUT=64, default thresholds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phase_sense_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        adc_locked;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_channel;
    logic        cmd_sop;
    logic        cmd_eop;
    logic        rsp_valid;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;
    logic [2:0]  current_sign;
    logic [2:0]  sign_valid;
    logic [2:0]  overcurrent;
    logic        fault;
    logic        timeout_err;

    int n_checks = 0;
    int n_errs   = 0;

    phase_sense_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_locked   (adc_locked),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_channel  (cmd_channel),
        .cmd_sop      (cmd_sop),
        .cmd_eop      (cmd_eop),
        .rsp_valid    (rsp_valid),
        .rsp_channel  (rsp_channel),
        .rsp_data     (rsp_data),
        .current_sign (current_sign),
        .sign_valid   (sign_valid),
        .overcurrent  (overcurrent),
        .fault        (fault),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        int         data;
        logic [2:0] sign;
        logic [2:0] sv;
        logic [2:0] oc;
        logic       flt;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cmd();
        int k = 0;
        while (cmd_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_valid_wait", {31'd0, cmd_valid}, 32'd1);
    endtask

    // One command handshake followed by a matching response on the next cycle.
    task automatic xact(input int ch, input int data);
        wait_cmd();
        chk("cmd_channel", {27'd0, cmd_channel}, ch);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b1;
        rsp_channel = 5'(ch);
        rsp_data    = 12'(data);
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    initial begin
        int seen;
        vecs[0]  = '{1, 3000, 3'b001, 3'b001, 3'b000, 1'b0};
        vecs[1]  = '{2, 1000, 3'b001, 3'b011, 3'b000, 1'b0};
        vecs[2]  = '{3, 3000, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[3]  = '{1, 2100, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[4]  = '{2, 1000, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[5]  = '{3, 3000, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[6]  = '{1, 2050, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[7]  = '{2, 1000, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[8]  = '{3, 3000, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[9]  = '{1, 2000, 3'b100, 3'b111, 3'b000, 1'b0};
        vecs[10] = '{2, 1000, 3'b100, 3'b111, 3'b000, 1'b0};
        vecs[11] = '{3, 3000, 3'b100, 3'b111, 3'b000, 1'b0};
        vecs[12] = '{1, 2050, 3'b100, 3'b111, 3'b000, 1'b0};
        vecs[13] = '{2, 4000, 3'b110, 3'b111, 3'b010, 1'b0};
        vecs[14] = '{3, 3000, 3'b110, 3'b111, 3'b010, 1'b1};
        vecs[15] = '{1, 2000, 3'b110, 3'b111, 3'b010, 1'b1};
        vecs[16] = '{2, 2000, 3'b100, 3'b111, 3'b010, 1'b1};
        vecs[17] = '{3,  195, 3'b000, 3'b111, 3'b110, 1'b1};
        vecs[18] = '{1, 3900, 3'b001, 3'b111, 3'b111, 1'b1};
        vecs[19] = '{2, 2016, 3'b001, 3'b111, 3'b111, 1'b1};
        vecs[20] = '{3, 2081, 3'b101, 3'b111, 3'b111, 1'b1};
        vecs[21] = '{1, 2080, 3'b101, 3'b111, 3'b111, 1'b1};

        rst = 1'b0; enable = 1'b0; adc_locked = 1'b0; cmd_ready = 1'b0;
        rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cmd_valid",   {31'd0, cmd_valid},    0);
        chk("rst_cmd_channel", {27'd0, cmd_channel},  0);
        chk("rst_sop",         {31'd0, cmd_sop},      1);
        chk("rst_eop",         {31'd0, cmd_eop},      1);
        chk("rst_sign",        {29'd0, current_sign}, 0);
        chk("rst_sv",          {29'd0, sign_valid},   0);
        chk("rst_oc",          {29'd0, overcurrent},  0);
        chk("rst_fault",       {31'd0, fault},        0);
        chk("rst_timeout",     {31'd0, timeout_err},  0);

        // Waiting for lock
        rst = 1'b1; enable = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) seen++;
        end
        chk("nolock_cmd_valid_cycles", seen, 0);
        adc_locked = 1'b1;
        @(negedge clk);
        chk("lock_cmd_valid",   {31'd0, cmd_valid},   1);
        chk("lock_cmd_channel", {27'd0, cmd_channel}, 1);

        // Round robin, hysteresis, over-current
        for (int i = 0; i < 22; i++) begin
            xact(vecs[i].ch, vecs[i].data);
            chk($sformatf("v%0d_sign", i),  {29'd0, current_sign}, {29'd0, vecs[i].sign});
            chk($sformatf("v%0d_sv", i),    {29'd0, sign_valid},   {29'd0, vecs[i].sv});
            chk($sformatf("v%0d_oc", i),    {29'd0, overcurrent},  {29'd0, vecs[i].oc});
            chk($sformatf("v%0d_fault", i), {31'd0, fault},        {31'd0, vecs[i].flt});
        end

        // Matching response on the watchdog expiry cycle (idx 1, channel 2)
        wait_cmd();
        chk("exp_cmd_channel", {27'd0, cmd_channel}, 2);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (63) @(negedge clk);
        chk("exp_pre_timeout", {31'd0, timeout_err}, 0);
        rsp_valid = 1'b1; rsp_channel = 5'd2; rsp_data = 12'd3000;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("exp_timeout",     {31'd0, timeout_err},  0);
        chk("exp_sign",        {29'd0, current_sign}, 3'b111);
        chk("exp_sv",          {29'd0, sign_valid},   3'b111);
        chk("exp_next_ch",     {27'd0, cmd_channel},  3);

        // Watchdog expiry on idx 2, with a stray response on another channel
        wait_cmd();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (8) @(negedge clk);
        rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd100;
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (54) @(negedge clk);
        chk("wd_pre_timeout",   {31'd0, timeout_err}, 0);
        chk("wd_pre_cmd_valid", {31'd0, cmd_valid},   0);
        @(negedge clk);
        chk("wd_timeout",   {31'd0, timeout_err},  1);
        chk("wd_sv",        {29'd0, sign_valid},   3'b011);
        chk("wd_sign_held", {29'd0, current_sign}, 3'b111);
        chk("wd_cmd_valid", {31'd0, cmd_valid},    1);
        chk("wd_next_ch",   {27'd0, cmd_channel},  1);

        // Enable dropped while waiting for a response
        wait_cmd();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("dis_sv",        {29'd0, sign_valid},   0);
        chk("dis_cmd_valid", {31'd0, cmd_valid},    0);
        chk("dis_sign",      {29'd0, current_sign}, 3'b111);
        chk("dis_oc",        {29'd0, overcurrent},  3'b111);
        chk("dis_timeout",   {31'd0, timeout_err},  1);
        rsp_valid = 1'b1; rsp_channel = 5'd1; rsp_data = 12'd1000;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp_sign", {29'd0, current_sign}, 3'b111);
        chk("late_rsp_sv",   {29'd0, sign_valid},   0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_cmd_valid",   {31'd0, cmd_valid},   1);
        chk("reen_cmd_channel", {27'd0, cmd_channel}, 1);

        // Asynchronous reset while a command is pending
        rst = 1'b0;
        #1;
        chk("arst_cmd_valid",   {31'd0, cmd_valid},    0);
        chk("arst_cmd_channel", {27'd0, cmd_channel},  0);
        chk("arst_sign",        {29'd0, current_sign}, 0);
        chk("arst_oc",          {29'd0, overcurrent},  0);
        chk("arst_fault",       {31'd0, fault},        0);
        chk("arst_timeout",     {31'd0, timeout_err},  0);
        chk("arst_sop",         {31'd0, cmd_sop},      1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
